// File: rtl/unified_ram_pkg.sv
// Shared constants for the single-cycle core's memory system.
package unified_ram_pkg;

    localparam int XLEN           = 32;
    localparam int MEM_ADDR_WIDTH = 16;

endpackage

// File: rtl/unified_ram.sv
// Unified instruction/data word memory: one shared array, a combinational read-only
// instruction port, and a data port with combinational read and clocked full-word write.
module unified_ram
    import unified_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = XLEN,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0] i_read_data,
    input  logic                  wEn,
    input  logic [ADDR_WIDTH-1:0] d_address,
    output logic [DATA_WIDTH-1:0] d_read_data,
    input  logic [DATA_WIDTH-1:0] d_write_data
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam int IDX_W = ADDR_WIDTH - 2;

    // Name is fixed: program images are preloaded hierarchically into this array.
    logic [DATA_WIDTH-1:0] ram [0:DEPTH-1];

    logic [IDX_W-1:0] i_index;
    logic [IDX_W-1:0] d_index;
    logic             write_en;

    assign i_index  = i_address[ADDR_WIDTH-1:2];
    assign d_index  = d_address[ADDR_WIDTH-1:2];
    assign write_en = wEn && !reset;

    // Byte-offset bits carry no meaning for word accesses.
    logic unused_offset_bits;
    assign unused_offset_bits = &{1'b0, i_address[1:0], d_address[1:0]};

    generate
        if (INIT_FILE != "") begin : g_image_note
            // The image named by INIT_FILE is placed into ram by the load flow.
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (write_en) begin
            ram[d_index] <= d_write_data;
        end
    end

    // Zero-latency reads: a write is seen only after the edge that commits it.
    assign i_read_data = ram[i_index];
    assign d_read_data = ram[d_index];

endmodule

// File: tb/tb_unified_ram.sv
// Self-checking bench for unified_ram: preload, aliasing, write gating, read-before-edge,
// reset-blocked writes and a randomized write/readback pass against a word model.
module tb_unified_ram;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic [AW-1:0] i_address;
    logic [DW-1:0] i_read_data;
    logic          wEn;
    logic [AW-1:0] d_address;
    logic [DW-1:0] d_read_data;
    logic [DW-1:0] d_write_data;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model [0:63];

    unified_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_FILE("")) dut (
        .clock        (clock),
        .reset        (reset),
        .i_address    (i_address),
        .i_read_data  (i_read_data),
        .wEn          (wEn),
        .d_address    (d_address),
        .d_read_data  (d_read_data),
        .d_write_data (d_write_data)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [DW-1:0] got);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got %h expected none", tag, got);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, got, e);
        end
    endtask

    // driver tasks: inputs change on the falling edge, outputs sampled 1ns later
    task automatic d_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
        @(negedge clock);
        wEn       = 1'b0;
        d_address = a;
        exp_q.push_back(e);
        #1;
        sb_check(tag, d_read_data);
    endtask

    task automatic i_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
        @(negedge clock);
        i_address = a;
        exp_q.push_back(e);
        #1;
        sb_check(tag, i_read_data);
    endtask

    task automatic d_write(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] data);
        @(negedge clock);
        wEn          = we;
        d_address    = a;
        d_write_data = data;
        @(negedge clock);
        wEn = 1'b0;
    endtask

    initial begin
        int          idx;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;

        reset        = 1'b1;
        wEn          = 1'b0;
        i_address    = '0;
        d_address    = '0;
        d_write_data = '0;

        // preload before the first clock edge
        model[0] = 32'h0000_0093;
        model[1] = 32'h0000_0113;
        model[2] = 32'h0000_0193;
        model[3] = 32'h1234_5678;
        model[4] = 32'h0BAD_C0DE;
        for (int k = 5; k < 64; k++) model[k] = 32'h1000_0000 + k;
        for (int k = 0; k < 64; k++) dut.ram[k] = model[k];

        // reads are combinational even under reset
        #1;
        exp_q.push_back(32'h0000_0093);
        sb_check("reset_iread_w0", i_read_data);
        d_read("reset_dread_w2", 16'd8, 32'h0000_0193);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        d_read("pre_w0", 16'd0, 32'h0000_0093);
        d_read("pre_w1", 16'd4, 32'h0000_0113);
        d_read("pre_w2", 16'd8, 32'h0000_0193);

        d_read("alias_1", 16'd1, 32'h0000_0093);
        d_read("alias_2", 16'd2, 32'h0000_0093);
        d_read("alias_3", 16'd3, 32'h0000_0093);
        d_read("alias_5", 16'd5, 32'h0000_0113);

        d_write(1'b0, 16'd4, 32'hDEAD_BEEF);
        d_read("wen0_w1", 16'd4, 32'h0000_0113);

        d_write(1'b1, 16'd8, 32'hFFFF_FFFF);
        model[2] = 32'hFFFF_FFFF;
        d_read("wr_w2_d", 16'd8, 32'hFFFF_FFFF);
        i_read("wr_w2_i", 16'd8, 32'hFFFF_FFFF);

        // read-before-edge on word 3, watched on both ports
        i_read("rbe_i_old", 16'd12, 32'h1234_5678);
        @(negedge clock);
        wEn          = 1'b1;
        d_address    = 16'd12;
        d_write_data = 32'hA5A5_A5A5;
        exp_q.push_back(32'h1234_5678);
        #1;
        sb_check("rbe_d_before", d_read_data);
        @(posedge clock);
        #1;
        exp_q.push_back(32'hA5A5_A5A5);
        sb_check("rbe_d_after", d_read_data);
        exp_q.push_back(32'hA5A5_A5A5);
        sb_check("rbe_i_after", i_read_data);
        @(negedge clock);
        wEn = 1'b0;
        model[3] = 32'hA5A5_A5A5;

        // reset blocks writes, contents retained
        @(negedge clock);
        reset = 1'b1;
        d_write(1'b1, 16'd16, 32'hCAFE_F00D);
        d_read("rst_blk_w4", 16'd16, 32'h0BAD_C0DE);
        d_read("rst_keep_w0", 16'd0, 32'h0000_0093);
        @(negedge clock);
        reset = 1'b0;
        d_write(1'b1, 16'd16, 32'hCAFE_F00D);
        model[4] = 32'hCAFE_F00D;
        d_read("rst_rel_w4", 16'd16, 32'hCAFE_F00D);

        // randomized writes/readbacks in words 32..63
        for (int n = 0; n < 12; n++) begin
            idx  = $urandom_range(32, 63);
            data = $urandom;
            addr = AW'(idx * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                d_write(1'b0, addr, data);
            end else begin
                d_write(1'b1, addr, data);
                model[idx] = data;
            end
            d_read("rnd_d", AW'(idx * 4 + $urandom_range(0, 3)), model[idx]);
            i_read("rnd_i", AW'(idx * 4 + $urandom_range(0, 3)), model[idx]);
        end

        // earlier words untouched by the random pass
        d_read("final_w2", 16'd8, model[2]);
        d_read("final_w3", 16'd12, model[3]);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
